// File: rtl/passcode_pkg.sv
// passcode_pkg
// Shared definitions for the passcode unit: the lock-state codes that the
// StateManager publishes, the non-digit key codes, and small helpers that
// classify keys and states.
package passcode_pkg;

  // Lock states as published by StateManager (110 is unused).
  typedef enum logic [2:0] {
    ST_OFF    = 3'b000,
    ST_ON     = 3'b001,
    ST_WRONG1 = 3'b010,
    ST_WRONG2 = 3'b011,
    ST_ANSWER = 3'b100,
    ST_RESET  = 3'b101,
    ST_LOCK   = 3'b111
  } lock_state_e;

  // Decoded keypad codes; 0-9 are digits and 13-15 carry no meaning.
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_STAR      = 4'd10;
  localparam logic [3:0] KEY_HASH      = 4'd11;
  localparam logic [3:0] KEY_CLR       = 4'd12;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= KEY_DIGIT_MAX);
  endfunction

  // States in which the user is typing a guess into the entry buffer.
  function automatic logic is_entry_state(input logic [2:0] st);
    logic r;
    case (st)
      ST_ON, ST_WRONG1, ST_WRONG2: r = 1'b1;
      default:                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/passcode_unit_if.sv
// passcode_unit_if
// Bundles the keypad/lock-state inputs and the comparison outputs of the
// passcode unit.
//   key_valid, key_code : one decoded key press per strobe cycle
//   state               : lock state from StateManager
//   initialize          : level, restores the default code
//   correct             : registered match / length-ok result
//   digit_count         : digits in the active buffer
//   entry_echo          : active buffer contents (only with PASSCODE_ECHO_EN)
// modport master drives keys and state; modport slave is the passcode unit.
interface passcode_unit_if #(
  parameter int MAX_LEN = 8
) ();
  localparam int CW = $clog2(MAX_LEN + 1);

  logic          key_valid;
  logic [3:0]    key_code;
  logic [2:0]    state;
  logic          initialize;
  logic          correct;
  logic [CW-1:0] digit_count;
`ifdef PASSCODE_ECHO_EN
  logic [4*MAX_LEN-1:0] entry_echo;

  modport master (output key_valid, key_code, state, initialize,
                  input  correct, digit_count, entry_echo);
  modport slave  (input  key_valid, key_code, state, initialize,
                  output correct, digit_count, entry_echo);
`else
  modport master (output key_valid, key_code, state, initialize,
                  input  correct, digit_count);
  modport slave  (input  key_valid, key_code, state, initialize,
                  output correct, digit_count);
`endif
endinterface

// File: rtl/passcode_buffer.sv
// passcode_buffer
// Digit accumulator: appends BCD digits at index count, saturates at
// MAX_LEN, and clears to all-zero slots. Slots at or above count stay 0.
//   clk, reset : clock and synchronous active-high reset
//   clear      : empty the buffer (wins over append)
//   append     : store digit at index count
//   digits     : registered contents, digit 0 in the low nibble
//   count      : registered number of stored digits
//   digits_nxt, count_nxt : values that will be registered at the next edge,
//                           so callers can produce results with one-cycle latency
module passcode_buffer #(
  parameter int MAX_LEN = 8,
  localparam int CW = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 append,
  input  logic [3:0]           digit,
  output logic [4*MAX_LEN-1:0] digits,
  output logic [CW-1:0]        count,
  output logic [4*MAX_LEN-1:0] digits_nxt,
  output logic [CW-1:0]        count_nxt
);
  localparam int            DW          = 4 * MAX_LEN;
  localparam logic [DW-1:0] ZERO_DIGITS = {DW{1'b0}};
  localparam logic [CW-1:0] ZERO_CNT    = {CW{1'b0}};
  localparam logic [CW-1:0] MAX_CNT     = CW'(MAX_LEN);
  localparam logic [CW-1:0] ONE_CNT     = CW'(1);

  logic [DW-1:0] digits_q, digits_d;
  logic [CW-1:0] count_q, count_d;

  // Next buffer contents: clear, saturating append, or hold.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (clear) begin
      digits_d = ZERO_DIGITS;
      count_d  = ZERO_CNT;
    end else if (append && (count_q < MAX_CNT)) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (count_q == CW'(i)) begin
          digits_d[4*i +: 4] = digit;
        end else begin
          digits_d[4*i +: 4] = digits_q[4*i +: 4];
        end
      end
      count_d = count_q + ONE_CNT;
    end else begin
      digits_d = digits_q;
      count_d  = count_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= ZERO_DIGITS;
      count_q  <= ZERO_CNT;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
    end
  end

  assign digits     = digits_q;
  assign count      = count_q;
  assign digits_nxt = digits_d;
  assign count_nxt  = count_d;

endmodule

// File: rtl/passcode_unit.sv
// passcode_unit
// Passcode store and comparator upstream of StateManager. Accumulates
// digits into the entry buffer (states on/wrong1/wrong2) or the new-code
// buffer (re-set state), compares against the stored code, and commits a
// new code when the lock leaves re-set for off with enough digits.
//   clk, reset : clock and synchronous active-high reset
//   bus        : passcode_unit_if.slave (keys, state, initialize, results)
// Optional feature macro: PASSCODE_ECHO_EN adds the registered entry_echo
// output carrying the active buffer contents.
module passcode_unit
  import passcode_pkg::*;
#(
  parameter int                   MAX_LEN      = 8,
  parameter int                   MIN_LEN      = 4,
  parameter logic [4*MAX_LEN-1:0] DEFAULT_CODE = {(4*MAX_LEN){1'b0}},
  parameter int                   DEFAULT_LEN  = 4
) (
  input logic            clk,
  input logic            reset,
  passcode_unit_if.slave bus
);
  localparam int            CW          = $clog2(MAX_LEN + 1);
  localparam int            DW          = 4 * MAX_LEN;
  localparam logic [DW-1:0] ZERO_DIGITS = {DW{1'b0}};
  localparam logic [CW-1:0] ZERO_CNT    = {CW{1'b0}};
  localparam logic [CW-1:0] MIN_CNT     = CW'(MIN_LEN);
  localparam logic [CW-1:0] DEF_CNT     = CW'(DEFAULT_LEN);

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] stored_code_q, stored_code_d;
  logic [CW-1:0] stored_len_q, stored_len_d;
  logic          correct_q, correct_d;
  logic [CW-1:0] digit_count_q, digit_count_d;

  logic          entry_active_s, new_active_s, clear_all_s, commit_s;
  logic          key_digit_s, key_clr_s;
  logic          entry_clear_s, entry_append_s, new_clear_s, new_append_s;
  logic [DW-1:0] entry_digits_s, entry_digits_nxt_s, new_digits_s, new_digits_nxt_s;
  logic [CW-1:0] entry_count_s, entry_count_nxt_s, new_count_s, new_count_nxt_s;
  logic [DW-1:0] prev_digits_s, active_digits_nxt_s;
  logic [CW-1:0] prev_count_s;
  logic          match_s;

  passcode_buffer #(.MAX_LEN(MAX_LEN)) u_entry_buf (
    .clk        (clk),
    .reset      (reset),
    .clear      (entry_clear_s),
    .append     (entry_append_s),
    .digit      (bus.key_code),
    .digits     (entry_digits_s),
    .count      (entry_count_s),
    .digits_nxt (entry_digits_nxt_s),
    .count_nxt  (entry_count_nxt_s)
  );

  passcode_buffer #(.MAX_LEN(MAX_LEN)) u_new_buf (
    .clk        (clk),
    .reset      (reset),
    .clear      (new_clear_s),
    .append     (new_append_s),
    .digit      (bus.key_code),
    .digits     (new_digits_s),
    .count      (new_count_s),
    .digits_nxt (new_digits_nxt_s),
    .count_nxt  (new_count_nxt_s)
  );

  // Key routing, state-change clearing and commit detection.
  always_comb begin
    state_d        = bus.state;
    entry_active_s = is_entry_state(bus.state);
    new_active_s   = (bus.state == ST_RESET);
    // Any state change (or initialize) empties both buffers and swallows a
    // coincident key.
    clear_all_s    = bus.initialize | (bus.state != state_q);
    key_digit_s    = bus.key_valid & ~clear_all_s & is_digit(bus.key_code);
    key_clr_s      = bus.key_valid & ~clear_all_s & (bus.key_code == KEY_CLR);
    entry_clear_s  = clear_all_s | (key_clr_s & entry_active_s);
    entry_append_s = key_digit_s & entry_active_s;
    new_clear_s    = clear_all_s | (key_clr_s & new_active_s);
    new_append_s   = key_digit_s & new_active_s;
    // Contents of the buffer that was active last cycle; in re-set this is
    // the new-code buffer that a commit copies from.
    if (state_q == ST_RESET) begin
      prev_digits_s = new_digits_s;
      prev_count_s  = new_count_s;
    end else begin
      prev_digits_s = entry_digits_s;
      prev_count_s  = entry_count_s;
    end
    commit_s = ~bus.initialize & (state_q == ST_RESET) & (bus.state == ST_OFF)
             & (prev_count_s >= MIN_CNT);
  end

  // Stored code update: initialize beats commit, otherwise hold.
  always_comb begin
    stored_code_d = stored_code_q;
    stored_len_d  = stored_len_q;
    if (bus.initialize) begin
      stored_code_d = DEFAULT_CODE;
      stored_len_d  = DEF_CNT;
    end else if (commit_s) begin
      stored_code_d = prev_digits_s;
      stored_len_d  = prev_count_s;
    end else begin
      stored_code_d = stored_code_q;
      stored_len_d  = stored_len_q;
    end
  end

  // Next-cycle comparison and count, built from the buffers' next values so
  // the outputs reflect a key one cycle after it arrives.
  always_comb begin
    correct_d     = 1'b0;
    digit_count_d = ZERO_CNT;
    if (entry_active_s) begin
      active_digits_nxt_s = entry_digits_nxt_s;
    end else if (new_active_s) begin
      active_digits_nxt_s = new_digits_nxt_s;
    end else begin
      active_digits_nxt_s = ZERO_DIGITS;
    end
    // Only the first stored_len digits take part in the comparison.
    match_s = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((CW'(i) < stored_len_d) &&
          (active_digits_nxt_s[4*i +: 4] != stored_code_d[4*i +: 4])) begin
        match_s = 1'b0;
      end else begin
        match_s = match_s;
      end
    end
    if (entry_active_s) begin
      correct_d     = (entry_count_nxt_s == stored_len_d) & match_s;
      digit_count_d = entry_count_nxt_s;
    end else if (new_active_s) begin
      correct_d     = (new_count_nxt_s >= MIN_CNT);
      digit_count_d = new_count_nxt_s;
    end else begin
      correct_d     = 1'b0;
      digit_count_d = ZERO_CNT;
    end
  end

  // Previous state, stored code and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_OFF;
      stored_code_q <= DEFAULT_CODE;
      stored_len_q  <= DEF_CNT;
      correct_q     <= 1'b0;
      digit_count_q <= ZERO_CNT;
    end else begin
      state_q       <= state_d;
      stored_code_q <= stored_code_d;
      stored_len_q  <= stored_len_d;
      correct_q     <= correct_d;
      digit_count_q <= digit_count_d;
    end
  end

  assign bus.correct     = correct_q;
  assign bus.digit_count = digit_count_q;

`ifdef PASSCODE_ECHO_EN
  logic [DW-1:0] entry_echo_q, entry_echo_d;

  // Echo source: the active buffer's next contents (zero with no active buffer).
  always_comb begin
    entry_echo_d = active_digits_nxt_s;
  end

  // Registered display echo.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_echo_q <= ZERO_DIGITS;
    end else begin
      entry_echo_q <= entry_echo_d;
    end
  end

  assign bus.entry_echo = entry_echo_q;
`endif

endmodule

// File: tb/tb_passcode_unit.sv
// Scoreboard bench for passcode_unit: each stimulus cycle queues the
// hand-computed correct/digit_count expected one cycle later; a monitor on
// the falling edge pops and compares.
module tb_passcode_unit;
  import passcode_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  passcode_unit_if #(.MAX_LEN(8)) bus ();

  passcode_unit #(
    .MAX_LEN(8), .MIN_LEN(4), .DEFAULT_CODE(32'h0000_0000), .DEFAULT_LEN(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] due;
    logic        c;
    logic [3:0]  n;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [2:0]  cur_st = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the scoreboard head when its cycle comes up.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks = checks + 1;
        if (bus.correct !== e.c || bus.digit_count !== e.n) begin
          failures = failures + 1;
          $display("FAIL %s: got correct=%0b digit_count=%0d, expected correct=%0b digit_count=%0d",
                   nm, bus.correct, bus.digit_count, e.c, e.n);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic [2:0] st, input logic kv,
                      input logic [3:0] kc, input logic init,
                      input logic ec, input logic [3:0] en, input string nm);
    exp_t e;
    reset          = rst;
    bus.state      = st;
    bus.key_valid  = kv;
    bus.key_code   = kc;
    bus.initialize = init;
    e.due = 32'(cyc + 1);
    e.c   = ec;
    e.n   = en;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] kc, input logic ec, input logic [3:0] en, input string nm);
    step(1'b0, cur_st, 1'b1, kc, 1'b0, ec, en, nm);
  endtask

  task automatic go(input logic [2:0] st, input string nm);
    cur_st = st;
    step(1'b0, st, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, nm);
  endtask

  // Four digits starting from an empty buffer; with a 4-digit stored code
  // only the fourth can produce correct=1.
  task automatic keys4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input logic last_c, input string nm);
    key(a, 1'b0, 4'd1, {nm, "_d1"});
    key(b, 1'b0, 4'd2, {nm, "_d2"});
    key(c, 1'b0, 4'd3, {nm, "_d3"});
    key(d, last_c, 4'd4, nm);
  endtask

  initial begin
    reset = 1'b1;
    bus.state = 3'b000;
    bus.key_valid = 1'b0;
    bus.key_code = 4'd0;
    bus.initialize = 1'b0;

    step(1'b1, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, "reset_a");
    step(1'b1, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, "reset_b");

    // Default code 0000.
    go(ST_ON, "enter_on");
    keys4(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, "default_match");
    key(4'd0, 1'b0, 4'd5, "len_mismatch");
    step(1'b0, ST_ON, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, "hold_idle");
    key(KEY_CLR, 1'b0, 4'd0, "clr");
    keys4(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, "rematch");

    // Re-set to 1234 and commit.
    go(ST_ANSWER, "to_answer");
    key(4'd5, 1'b0, 4'd0, "answer_ignores");
    go(ST_RESET, "to_reset");
    key(4'd1, 1'b0, 4'd1, "new_d1");
    key(4'd2, 1'b0, 4'd2, "new_d2");
    key(4'd3, 1'b0, 4'd3, "short_new");
    key(4'd4, 1'b1, 4'd4, "min_len_new");
    go(ST_OFF, "commit_1234");
    go(ST_ON, "on_after_commit");
    keys4(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, "new_code_ok");
    key(KEY_CLR, 1'b0, 4'd0, "clr2");
    keys4(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "old_rejected");

    // Too-short re-set leaves 1234 in place.
    go(ST_ANSWER, "to_answer2");
    go(ST_RESET, "to_reset2");
    key(4'd9, 1'b0, 4'd1, "short_d1");
    key(4'd9, 1'b0, 4'd2, "short_d2");
    key(4'd9, 1'b0, 4'd3, "short_d3");
    go(ST_OFF, "no_commit");
    go(ST_ON, "on_after_no_commit");
    keys4(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, "short_not_committed");

    // Commit 5678, then initialize.
    go(ST_ANSWER, "to_answer3");
    go(ST_RESET, "to_reset3");
    keys4(4'd5, 4'd6, 4'd7, 4'd8, 1'b1, "new_5678");
    go(ST_OFF, "commit_5678");
    go(ST_ON, "on_5678");
    keys4(4'd5, 4'd6, 4'd7, 4'd8, 1'b1, "code_5678_ok");
    step(1'b0, ST_ON, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, "init_clears");
    step(1'b0, ST_ON, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, "after_init");
    keys4(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, "init_default_ok");
    key(KEY_CLR, 1'b0, 4'd0, "clr3");
    keys4(4'd5, 4'd6, 4'd7, 4'd8, 1'b0, "code_5678_rejected");

    // Saturation at 8 digits.
    key(KEY_CLR, 1'b0, 4'd0, "clr4");
    for (int i = 1; i <= 9; i++) begin
      key(4'd1, 1'b0, (i > 8) ? 4'd8 : 4'(i), (i > 8) ? "saturate" : "fill");
    end

    // Digit coincident with a state change is dropped; non-digit keys.
    cur_st = ST_WRONG1;
    step(1'b0, ST_WRONG1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, "drop_on_change");
    key(4'd3, 1'b0, 4'd1, "wrong1_digit");
    key(KEY_STAR, 1'b0, 4'd1, "star_not_stored");
    key(KEY_HASH, 1'b0, 4'd1, "hash_not_stored");
    key(4'd13, 1'b0, 4'd1, "key13_ignored");
    key(KEY_CLR, 1'b0, 4'd0, "clr5");
    keys4(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, "wrong1_match");

    go(ST_LOCK, "to_lock");
    key(4'd1, 1'b0, 4'd0, "lock_ignores");

    // Reset in the middle of re-set discards the uncommitted code.
    go(ST_ANSWER, "to_answer4");
    go(ST_RESET, "to_reset4");
    keys4(4'd5, 4'd6, 4'd7, 4'd8, 1'b1, "new_5678_again");
    step(1'b1, ST_RESET, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, "mid_reset");
    go(ST_OFF, "off_after_reset");
    go(ST_ON, "on_after_reset");
    keys4(4'd5, 4'd6, 4'd7, 4'd8, 1'b0, "reset_discards_new");
    key(KEY_CLR, 1'b0, 4'd0, "clr6");
    keys4(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, "default_after_reset");

    bus.key_valid = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures = failures + 1;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/passcode_unit.md
# passcode_unit

Keypad-side passcode store and comparator that sits directly upstream of `StateManager`. It takes decoded key presses, tracks the lock state that `StateManager` publishes, and accumulates the entered digits. It produces the `correct` level that `StateManager` samples on a `*` press. In the re-set state it captures a new passcode and commits it when the lock returns to off.

## Interface
- `MAX_LEN`, 8: maximum digits held by the stored code and each buffer.
- `MIN_LEN`, 4: minimum length of a new passcode.
- `DEFAULT_CODE`, 32'h0000_0000: power-up/initialize code, 4-bit BCD per digit, digit 0 in the low nibble.
- `DEFAULT_LEN`, 4: length of `DEFAULT_CODE`.
- `clk`  in  1  system clock; every register updates on posedge.
- `reset`  in  1  synchronous, active-high hardware reset.
- `key_valid`  in  1  single-cycle strobe; `key_code` is valid in this cycle.
- `key_code`  in  4  0–9 are digits; 10 is `*`; 11 is `#`; 12 is CLR; 13–15 are ignored.
- `state`  in  3  lock state from `StateManager`: 000 off, 001 on, 010 wrong1, 011 wrong2, 100 answer, 101 reset, 111 lock.
- `initialize`  in  1  initialize button (level).
- `correct`  out  1  registered comparison/length result.
- `digit_count`  out  `$clog2(MAX_LEN+1)`  digits in the active buffer.

## Operation
- Active buffer:
  - In states 001/010/011 the active buffer is the entry buffer.
  - In state 101 it is the new-code buffer.
  - In 000, 100 and 111 there is no active buffer: digits are ignored, `correct`=0 and `digit_count`=0.
- A digit key appends to the active buffer at index `count`; `count` increments.
  - When `count`==`MAX_LEN`, further digits are dropped and `count` saturates.
- CLR empties the active buffer: `count`=0 and all digit slots are zeroed.
- `*` and `#` are not stored; they are consumed by `StateManager` logic elsewhere.
- State-change clear: a registered `state_q` holds the previous `state`. When `state`≠`state_q`, both buffers are cleared.
- `correct`:
  - In 001/010/011: `correct` = (entry `count`==`stored_len`) AND (all `stored_len` digits equal).
  - In 101: `correct` = (new-code `count` ≥ `MIN_LEN`).
- Commit: on the transition `state_q`=101 → `state`=000 with new-code `count` ≥ `MIN_LEN`:
  - stored code ← new-code buffer, and `stored_len` ← `count`;
  - otherwise the stored code is unchanged.
- Initialize: while `initialize`=1, the stored code ← `DEFAULT_CODE`, `stored_len` ← `DEFAULT_LEN`, both buffers are cleared and all key input is ignored.
- Priority, highest first: `reset`, `initialize`, commit/state-change clear, CLR, digit. A key arriving in the same cycle as a state change is dropped.
- Digit slots at or above `count` always read 0; comparison covers only indices below `stored_len`.

## Timing
- Reset values:
  - `correct`=0, `digit_count`=0;
  - both buffers empty, stored code = `DEFAULT_CODE`/`DEFAULT_LEN`, `state_q`=000.
- Latency: a key in cycle N is reflected in `digit_count` and `correct` at cycle N+1.
- `correct` stays stable while `state` is constant and no key arrives. It therefore holds across the slow sampling of `StateManager` (one sample per 50000 clocks).
- `reset` asserted mid-entry or mid-re-set discards all buffers and any new code that has not been committed.
- `key_valid` held high for k cycles counts as k presses; debouncing and edge detection happen upstream.

## Configuration
- `PASSCODE_ECHO_EN`:
  - When defined, the block adds output `entry_echo [4*MAX_LEN-1:0]`, the registered active-buffer contents for the 7-segment display. It follows the same N+1 latency as `digit_count` and resets to 0.
  - When not defined, the port and its registers are absent; only `digit_count` is exported.

## Structure
- `passcode_pkg`:
  - state codes `ST_OFF`, `ST_ON`, `ST_WRONG1`, `ST_WRONG2`, `ST_ANSWER`, `ST_RESET`, `ST_LOCK`;
  - key codes `KEY_STAR`=10, `KEY_HASH`=11, `KEY_CLR`=12.
- Sub-module `passcode_buffer`, instantiated twice (entry and new-code):
  - append, clear and saturating count;
  - exposes `digits` and `count`.
- The stored code, commit logic, comparator and `state_q` live in the top level.

## Test plan
- After reset, in state 001, press 0,0,0,0 → `digit_count`=4 and `correct`=1 one cycle after the 4th key.
- In state 001, press 0,0,0 → `correct`=0. Press a 4th 0 → `correct`=1. Press a 5th 0 → `correct`=0 (length mismatch).
- Walk 100→101, press 1,2,3 → `correct`=0. Press 4 → `correct`=1. Move to 000, then 001, press 1,2,3,4 → `correct`=1; press 0,0,0,0 instead → `correct`=0.
- Walk 101→000 with only 3 digits entered → stored code stays 0000.
- Commit 5678, then pulse `initialize` → 0000 is accepted again and 5678 is rejected.
- In state 001, press 9 digits → `digit_count` saturates at 8. A digit coincident with a state change is dropped and `digit_count`=0. CLR → `digit_count`=0.
